port_debounce: RTL and testbench

//  Conditions raw push-button/switch lines before they reach the CPU input port
//  (PORTI) of comp. Each bit is synchronised, debounced on a shared sample tick,
//  and produces a stable level, single-cycle edge pulses and sticky rise-capture

---
 rtl/port_debounce.sv | 124 ++++++++++++
 tb/tb_port_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/port_debounce.sv
// port_debounce
//   Conditions raw push-button/switch lines before they reach the CPU input
//   port (PORTI). Each line is synchronised, debounced on a shared sample
//   tick, and yields a stable level, single-cycle edge pulses and sticky
//   rise-capture bits that software clears with a write-1-to-clear strobe.
//
// Parameters
//   WIDTH     number of input lines
//   PRESC     clk cycles per debounce sample tick (>=1, 1 = every cycle)
//   DB_TICKS  consecutive ticks a new level must persist before acceptance (>=1)
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-low reset
//   din       raw asynchronous inputs
//   clr_en    capture-clear strobe (one cycle)
//   clr_mask  capture bits to clear when clr_en=1
//   dout      debounced level
//   rise      1-cycle pulse when dout[i] goes 0->1
//   fall      1-cycle pulse when dout[i] goes 1->0
//   cap       sticky rise capture, cleared via clr_en/clr_mask
//   any_cap   OR-reduction of cap
module port_debounce #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESC    = 1000,
    parameter int unsigned DB_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] cap,
    output logic             any_cap
);

    localparam int unsigned CW = $clog2(DB_TICKS + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] s;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] cap_nxt;

    // Two-flop synchroniser; first stage feeds nothing but the second.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= din;
            s     <= sync1;
        end
    end

    // Shared sample tick, high during the last cycle of each PRESC period.
    generate
        if (PRESC == 1) begin : g_tick_always
            assign tick = 1'b1;
        end else begin : g_tick_presc
            localparam int unsigned PW = $clog2(PRESC);
            logic [PW-1:0] presc_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    presc_cnt <= '0;
                end else if (presc_cnt == PW'(PRESC - 1)) begin
                    presc_cnt <= '0;
                end else begin
                    presc_cnt <= presc_cnt + 1'b1;
                end
            end

            assign tick = (presc_cnt == PW'(PRESC - 1));
        end
    endgenerate

    // A bit is accepted on the tick that completes DB_TICKS agreeing samples.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            accept[i] = tick && (s[i] != dout[i]) && (cnt[i] == CW'(DB_TICKS - 1));
        end
    end

    // A fresh rise sets the capture even when the same bit is being cleared.
    assign cap_nxt = rise | (cap & ~({WIDTH{clr_en}} & clr_mask));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            dout    <= '0;
            rise    <= '0;
            fall    <= '0;
            cap     <= '0;
            any_cap <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s[i] == dout[i]) begin
                    // Any return to the current level restarts qualification.
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (accept[i]) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            dout    <= dout ^ accept;
            rise    <= accept & s;
            fall    <= accept & ~s;
            cap     <= cap_nxt;
            any_cap <= |cap_nxt;
        end
    end

endmodule

// File: tb/tb_port_debounce.sv
module tb_port_debounce;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        clr_en;
    logic [31:0] clr_mask;
    logic [31:0] dout;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] cap;
    logic        any_cap;

    int n_tests = 0;
    int n_fail  = 0;

    // Edge-pulse tallies, sampled mid-cycle while out of reset.
    int rise0_cnt = 0;
    int rise2_cnt = 0;
    int fall2_cnt = 0;
    int edge_cnt  = 0;

    port_debounce #(
        .WIDTH   (32),
        .PRESC   (4),
        .DB_TICKS(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .clr_en  (clr_en),
        .clr_mask(clr_mask),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .cap     (cap),
        .any_cap (any_cap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (rise[0])        rise0_cnt++;
            if (rise[2])        rise2_cnt++;
            if (fall[2])        fall2_cnt++;
            if ((|rise) || (|fall)) edge_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Step cycles (sampling 1 time unit after each edge) until dout matches.
    task automatic wait_dout(input logic [31:0] exp, input int max, output int n);
        n = 0;
        while (n < max && dout !== exp) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk); #1;
        end
    endtask

    int n;
    int r0, r2, f2, e0;
    int bad;

    initial begin
        reset    = 1'b0;
        din      = 32'hFFFF_FFFF;
        clr_en   = 1'b0;
        clr_mask = '0;

        // 1: reset state, then qualification of all-ones after release
        step(3);
        check("rst_dout", dout, 32'h0);
        check("rst_rise", rise, 32'h0);
        check("rst_fall", fall, 32'h0);
        check("rst_cap",  cap,  32'h0);
        check("rst_anycap", {31'h0, any_cap}, 32'h0);
        reset = 1'b1;
        wait_dout(32'hFFFF_FFFF, 30, n);
        check("t1_latency", n, 32'd12);
        check("t1_rise_on", rise, 32'hFFFF_FFFF);
        check("t1_fall_on", fall, 32'h0);
        step(1);
        check("t1_rise_off", rise, 32'h0);
        check("t1_cap", cap, 32'hFFFF_FFFF);
        check("t1_anycap", {31'h0, any_cap}, 32'h1);

        // Return to all-zero and clear every capture bit
        din = 32'h0;
        wait_dout(32'h0, 30, n);
        check("t1_back0", dout, 32'h0);
        step(2);
        clr_en = 1'b1; clr_mask = 32'hFFFF_FFFF;
        step(1);
        clr_en = 1'b0; clr_mask = 32'h0;
        check("clr_all_cap", cap, 32'h0);
        check("clr_all_any", {31'h0, any_cap}, 32'h0);
        step(20);

        // 2: 6-cycle pulse on din[2] is a bounce
        e0 = edge_cnt;
        din[2] = 1'b1;
        step(6);
        din[2] = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (dout[2] !== 1'b0) bad++;
        end
        check("t2_dout_stuck0", bad, 32'd0);
        check("t2_no_edges", edge_cnt - e0, 32'd0);

        // 3: held press and release on bit 2
        r2 = rise2_cnt; f2 = fall2_cnt;
        din = 32'd4;
        wait_dout(32'd4, 20, n);
        check("t3_rise_lat_ok", {31'h0, (n >= 11 && n <= 15)}, 32'h1);
        if (n < 40) step(40 - n);
        din = 32'd0;
        wait_dout(32'd0, 20, n);
        check("t3_fall_lat_ok", {31'h0, (n >= 11 && n <= 15)}, 32'h1);
        step(3);
        check("t3_rise_pulses", rise2_cnt - r2, 32'd1);
        check("t3_fall_pulses", fall2_cnt - f2, 32'd1);
        check("t3_cap", cap, 32'd4);
        check("t3_anycap", {31'h0, any_cap}, 32'h1);

        // 4: clear behaviour
        clr_en = 1'b1; clr_mask = 32'h0;
        step(1);
        clr_en = 1'b0;
        check("t4_mask0_cap", cap, 32'd4);
        clr_en = 1'b1; clr_mask = 32'h4;
        step(1);
        clr_en = 1'b0; clr_mask = 32'h0;
        check("t4_clr_cap", cap, 32'd0);
        check("t4_clr_any", {31'h0, any_cap}, 32'h0);
        din = 32'd4;
        n = 0;
        while (n < 20 && rise[2] !== 1'b1) begin
            step(1);
            n++;
        end
        check("t4_rise_seen", {31'h0, rise[2]}, 32'h1);
        clr_en = 1'b1; clr_mask = 32'h4;
        step(1);
        clr_en = 1'b0; clr_mask = 32'h0;
        check("t4_set_wins", cap, 32'd4);
        check("t4_set_wins_any", {31'h0, any_cap}, 32'h1);
        din = 32'd0;
        wait_dout(32'd0, 20, n);
        check("t4_back0", dout, 32'd0);
        step(3);

        // 5: din[0] toggling every 3 cycles never qualifies
        r0 = rise0_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0) din[0] = ~din[0];
            step(1);
            if (dout[0] !== 1'b0) bad++;
        end
        din[0] = 1'b0;
        check("t5_dout0_low", bad, 32'd0);
        check("t5_no_rise", rise0_cnt - r0, 32'd0);
        step(20);

        // 6: reset mid-qualification restarts everything
        din = 32'd1;
        step(8);
        check("t6_pre_dout", dout, 32'd0);
        reset = 1'b0;
        #1;
        check("t6_async_cap", cap, 32'd0);
        check("t6_async_any", {31'h0, any_cap}, 32'h0);
        step(2);
        reset = 1'b1;
        r0 = rise0_cnt;
        wait_dout(32'd1, 30, n);
        check("t6_latency", n, 32'd12);
        step(10);
        check("t6_rise_pulses", rise0_cnt - r0, 32'd1);
        check("t6_cap", cap, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
